// File: rtl/adc045_pkg.sv
// Shared definitions for the ADC045 device-side emulator: opcodes, config
// field positions, sequencer states and the data-rate period multiplier.
package adc045_pkg;

   localparam logic [7:0] OP_RESET = 8'h06;
   localparam logic [7:0] OP_RDATA = 8'h12;
   localparam logic [7:0] OP_RREG  = 8'h20;
   localparam logic [7:0] OP_WREG  = 8'h40;

   localparam int CFG_W    = 14;
   localparam int SAMPLE_W = 24;

   localparam int POL_B     = 13;
   localparam int GAIN_MSB  = 12;
   localparam int GAIN_LSB  = 10;
   localparam int REF_B     = 9;
   localparam int MODE_B    = 8;
   localparam int DR_MSB    = 7;
   localparam int DR_LSB    = 6;
   localparam int T1_MSB    = 5;
   localparam int T1_LSB    = 4;
   localparam int SCALE_B   = 3;
   localparam int BUF_DIS_B = 2;
   localparam int T2_MSB    = 1;
   localparam int T2_LSB    = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WR,
      ST_RD_SHIFT,
      ST_DONE
   } spi_state_t;

   function automatic int unsigned dr_mult(input logic [1:0] dr);
      case (dr)
         2'b00:   return 1;
         2'b01:   return 4;
         2'b10:   return 16;
         default: return 64;
      endcase
   endfunction

   // Field-wise copy so every defined config bit position is explicit.
   function automatic logic [CFG_W-1:0] cfg_from_word(input logic [CFG_W-1:0] w);
      logic [CFG_W-1:0] c;
      c = '0;
      c[POL_B]             = w[POL_B];
      c[GAIN_MSB:GAIN_LSB] = w[GAIN_MSB:GAIN_LSB];
      c[REF_B]             = w[REF_B];
      c[MODE_B]            = w[MODE_B];
      c[DR_MSB:DR_LSB]     = w[DR_MSB:DR_LSB];
      c[T1_MSB:T1_LSB]     = w[T1_MSB:T1_LSB];
      c[SCALE_B]           = w[SCALE_B];
      c[BUF_DIS_B]         = w[BUF_DIS_B];
      c[T2_MSB:T2_LSB]     = w[T2_MSB:T2_LSB];
      return c;
   endfunction

endpackage

// File: rtl/adc045_spi_sync.sv
// 3-FF synchronizers for the asynchronous SPI pins, with single-cycle
// SCLK rise/fall and CS fall/rise pulses aligned to the synchronized DIN.
module adc045_spi_sync (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic cs,
   input  logic din,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic din_s
);

   logic [3:0] sclk_q;
   logic [3:0] cs_q;
   logic [2:0] din_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_q <= '0;
         cs_q   <= '1;
         din_q  <= '0;
      end else begin
         sclk_q <= {sclk_q[2:0], sclk};
         cs_q   <= {cs_q[2:0], cs};
         din_q  <= {din_q[1:0], din};
      end
   end

   // Stage 3 is the synchronized value; stage 4 only serves edge detection.
   assign sclk_rise = sclk_q[2] & ~sclk_q[3];
   assign sclk_fall = ~sclk_q[2] & sclk_q[3];
   assign cs_fall   = ~cs_q[2] & cs_q[3];
   assign cs_rise   = cs_q[2] & ~cs_q[3];
   assign din_s     = din_q[2];

endmodule

// File: rtl/adc045_emu.sv
// ADC045 device-side emulator: SPI command slave, conversion timer and DRDY.
// Define ADC045_EMU_RAMP_EN to replace ch0_i/ch1_i with internal ramp counters.
module adc045_emu #(
   parameter int CONV_DIV = 1000,
   parameter int CMD_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SCLK,
   input  logic        CS,
   input  logic        DIN,
   output logic        DOUT,
   output logic        DRDY,
   input  logic        nRST,
   input  logic        START,
   input  logic [23:0] ch0_i,
   input  logic [23:0] ch1_i,
   output logic [13:0] cfg_o,
   output logic        conv_o,
   output logic        ch_o
);
   import adc045_pkg::*;

   localparam logic [4:0] CMD_LAST = 5'(CMD_W - 1);

   logic                dev_rst;
   logic [1:0]          nrst_q;
   logic                sclk_rise, sclk_fall, cs_fall, cs_rise, din_s;
   spi_state_t          state, state_nxt;
   logic [4:0]          bit_cnt, out_last;
   logic [12:0]         sh_in;
   logic [CFG_W-1:0]    sh_nxt;
   logic [SAMPLE_W-1:0] out_sr, data_reg, raw0, raw1, raw, sample;
   logic [CFG_W-1:0]    cfg;
   logic                dout_q, rd_is_data, rd_busy;
   logic                drdy_q, drdy_pend;
   logic                ld_rreg, ld_rdata, cfg_we, op_reset, bit_clr;
   logic [31:0]         timer, period;
   logic                tmr_clr, conv_hit, conv_q, ch_q, ch_next, cur_ch;

   always_ff @(posedge clk) begin
      if (rst) nrst_q <= '0;
      else     nrst_q <= {nrst_q[0], nRST};
   end
   assign dev_rst = rst | ~nrst_q[1];

   adc045_spi_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .sclk      (SCLK),
      .cs        (CS),
      .din       (DIN),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .din_s     (din_s)
   );

   assign sh_nxt = {sh_in, din_s};

   always_ff @(posedge clk) begin
      if (dev_rst) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_rreg   = 1'b0;
      ld_rdata  = 1'b0;
      cfg_we    = 1'b0;
      op_reset  = 1'b0;
      bit_clr   = 1'b0;
      if (cs_rise) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
            ST_CMD: begin
               if (sclk_rise && bit_cnt == CMD_LAST) begin
                  bit_clr = 1'b1;
                  case (sh_nxt[CMD_W-1:0])
                     OP_RESET: begin op_reset = 1'b1; state_nxt = ST_DONE; end
                     OP_RDATA: begin ld_rdata = 1'b1; state_nxt = ST_RD_SHIFT; end
                     OP_RREG:  begin ld_rreg  = 1'b1; state_nxt = ST_RD_SHIFT; end
                     OP_WREG:  state_nxt = ST_WR;
                     default:  state_nxt = ST_DONE;
                  endcase
               end
            end
            ST_WR: begin
               if (sclk_rise && bit_cnt == 5'd15) begin
                  cfg_we    = 1'b1;
                  state_nxt = ST_DONE;
               end
            end
            ST_RD_SHIFT: if (sclk_fall && bit_cnt == out_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign rd_busy = (state == ST_RD_SHIFT) && rd_is_data;

   // Shift path: words are left-aligned in out_sr so the MSB is always bit 23.
   always_ff @(posedge clk) begin
      if (dev_rst) begin
         bit_cnt    <= '0;
         sh_in      <= '0;
         out_sr     <= '0;
         out_last   <= '0;
         rd_is_data <= 1'b0;
         dout_q     <= 1'b0;
         cfg        <= '0;
      end else begin
         if (cs_fall || bit_clr)
            bit_cnt <= '0;
         else if ((sclk_rise && (state == ST_CMD || state == ST_WR)) ||
                  (sclk_fall && state == ST_RD_SHIFT))
            bit_cnt <= bit_cnt + 5'd1;

         if (sclk_rise) sh_in <= sh_nxt[12:0];

         if (cs_rise)        dout_q <= 1'b0;
         else if (sclk_fall) dout_q <= (state == ST_RD_SHIFT) ? out_sr[SAMPLE_W-1] : 1'b0;

         if (ld_rreg) begin
            out_sr     <= {2'b00, cfg, 8'h00};
            out_last   <= 5'd15;
            rd_is_data <= 1'b0;
         end else if (ld_rdata) begin
            out_sr     <= data_reg;
            out_last   <= 5'd23;
            rd_is_data <= 1'b1;
         end else if (sclk_fall && state == ST_RD_SHIFT) begin
            out_sr <= {out_sr[SAMPLE_W-2:0], 1'b0};
         end

         if (op_reset)    cfg <= '0;
         else if (cfg_we) cfg <= cfg_from_word(sh_nxt);
      end
   end

`ifdef ADC045_EMU_RAMP_EN
   logic [SAMPLE_W-1:0] ramp0, ramp1;
   always_ff @(posedge clk) begin
      if (dev_rst) begin
         ramp0 <= '0;
         ramp1 <= '0;
      end else if (conv_hit) begin
         ramp0 <= ramp0 + 24'd1;
         ramp1 <= ramp1 - 24'd1;
      end
   end
   assign raw0 = ramp0;
   assign raw1 = ramp1;
`else
   assign raw0 = ch0_i;
   assign raw1 = ch1_i;
`endif

   assign cur_ch = cfg[MODE_B] & ch_next;
   assign raw    = cur_ch ? raw1 : raw0;
   // Negation saturates so full-scale negative maps to full-scale positive.
   assign sample = !cfg[POL_B] ? raw :
                   (raw == 24'h800000) ? 24'h7FFFFF : (~raw + 24'd1);

   assign period   = 32'(CONV_DIV) * dr_mult(cfg[DR_MSB:DR_LSB]);
   assign tmr_clr  = !START || op_reset ||
                     (cfg_we && (sh_nxt[DR_MSB:DR_LSB] != cfg[DR_MSB:DR_LSB]));
   assign conv_hit = !tmr_clr && (timer == period - 32'd1);

   always_ff @(posedge clk) begin
      if (dev_rst) begin
         timer     <= '0;
         ch_next   <= 1'b0;
         conv_q    <= 1'b0;
         ch_q      <= 1'b0;
         data_reg  <= '0;
         drdy_q    <= 1'b1;
         drdy_pend <= 1'b0;
      end else begin
         conv_q <= conv_hit;
         if (tmr_clr) begin
            timer   <= '0;
            ch_next <= 1'b0;
         end else if (conv_hit) begin
            timer   <= '0;
            ch_next <= cfg[MODE_B] & ~ch_next;
         end else begin
            timer <= timer + 32'd1;
         end

         if (conv_hit) begin
            data_reg <= sample;
            ch_q     <= cur_ch;
         end

         // A conversion during an RDATA shift defers DRDY until CS rises.
         if (conv_hit && rd_busy && !cs_rise) drdy_pend <= 1'b1;
         else if (cs_rise)                    drdy_pend <= 1'b0;

         if (conv_hit && (!rd_busy || cs_rise))             drdy_q <= 1'b0;
         else if (cs_rise && drdy_pend)                     drdy_q <= 1'b0;
         else if (sclk_fall && rd_busy && bit_cnt == 5'd0)  drdy_q <= 1'b1;
      end
   end

   assign DOUT   = dout_q & ~CS;
   assign DRDY   = drdy_q;
   assign cfg_o  = cfg;
   assign conv_o = conv_q;
   assign ch_o   = ch_q;

endmodule

// File: doc/adc045_emu.md
Name: adc045_emu

Overview:
- Cycle-level behavioural model of the ADC045 device side of the SPI link, synthesizable for FPGA loopback and for use in benches.
- Responds to the adc045 master as the real converter does: accepts WREG/RREG/RDATA/RESET frames, runs a conversion timer gated by START/nRST, and asserts DRDY when a new 24-bit sample is ready.
- Sits on the board-facing pins in place of the physical ADC.

Parameters:
- CONV_DIV, 1000, clk cycles per conversion at DR=2'b00. DR=01/10/11 multiply by 4/16/64.
- CMD_W, 8, command opcode width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- SCLK  in  1  SPI clock from master, asynchronous
- CS  in  1  chip select, active low, asynchronous
- DIN  in  1  master-to-device data, asynchronous
- DOUT  out  1  device-to-master data
- DRDY  out  1  data ready, active low
- nRST  in  1  device reset pin, active low
- START  in  1  conversion enable pin
- ch0_i  in  24  channel 1 sample source
- ch1_i  in  24  channel 2 sample source
- cfg_o  out  14  current config {POL,GAIN[2:0],REF,MODE,DR[1:0],T1[1:0],SCALE,BUF_DIS,T2[1:0]}
- conv_o  out  1  one-clk pulse per completed conversion
- ch_o  out  1  channel of the last converted sample

Behaviour:
- Reset (rst=1): DOUT=0, DRDY=1, cfg_o=0, conv_o=0, ch_o=0, timer=0, FSM=IDLE.
- nRST=0: same state as reset, held while low. Sampled through a 2-FF synchronizer.
- SCLK, CS and DIN pass through 3-FF synchronizers, giving 3 clk cycles of latency. SCLK high and low phases must each last at least 4 clk cycles.
- Edge timing: DIN is sampled on the detected SCLK rise. DOUT changes on the detected SCLK fall. DOUT=0 whenever CS=1.
- FSM states:
  - IDLE: CS falling goes to CMD with bit count 0.
  - CMD: shift 8 bits in MSB first. At bit 8, decode the opcode.
  - WR: shift 16 bits in. On bit 16, cfg <= shifted[13:0] and the top 2 bits are ignored. Go to DONE.
  - RD_SHIFT: load the shift register with 16 bits {2'b00,cfg} for RREG, or 24 bits data_reg for RDATA. Drive the MSB on the next SCLK fall, then one bit per fall. After the last bit, go to DONE.
  - DONE: ignore further bits until CS rises.
- Opcodes (MSB first): RESET=0x06 (cfg<=0, timer<=0, effective at bit 8), RDATA=0x12, RREG=0x20, WREG=0x40. Any other opcode goes to DONE with no effect.
- CS rising in any state returns the FSM to IDLE. A partial WREG frame leaves cfg unchanged.
- Conversion timer:
  - Counts only while START=1 and nRST=1.
  - Period = CONV_DIV × {1,4,16,64}[DR].
  - START=0 clears the timer. The first conversion completes one full period after START rises.
  - A WREG that changes DR also clears the timer.
- On conversion complete:
  - data_reg <= ch0_i or ch1_i per the channel, ch_o <= channel, conv_o pulses for 1 clk.
  - DRDY goes low, unless an RDATA shift is in progress; in that case DRDY goes low on CS rising.
- Channel selection: MODE=0 always uses ch0. MODE=1 alternates 0,1,0,… with the first conversion after a timer clear on ch0.
- DRDY returns high on the first SCLK fall of an RDATA data phase. The shift register holds a snapshot, so a mid-read conversion never corrupts the bits being shifted out.
- POL=1: the stored sample is two's-complement negated (0x800000 maps to 0x7FFFFF). GAIN, REF, SCALE and BUF_DIS are stored and read back only.

Optional Feature:
- ADC045_EMU_RAMP_EN defined: ch0_i and ch1_i are ignored. The samples come from internal 24-bit counters that increment per conversion: ch0 by +1, ch1 by -1, and both reset to 0.
- Undefined: samples are taken from the inputs.

Decomposition:
- Shared package adc045_pkg holds:
  - opcode localparams;
  - cfg bit-index localparams (POL_B=13 … T2_LSB=0);
  - the DR multiplier function.
- Sub-module adc045_spi_sync: 3-FF synchronizers plus SCLK rise/fall and CS fall/rise pulse outputs.

Test Plan:
- WREG 0x40 then 0x01,0x00 (cfg=14'h0100, MODE=1) followed by RREG -> DOUT returns 16'h0100 and cfg_o=14'h0100.
- START=1, DR=00, CONV_DIV=1000 -> DRDY falls at 1000 clk after START and every 1000 clk after that; conv_o pulses each time.
- ch0_i=24'h123456, one conversion, RDATA -> 24 bits 0x123456 MSB first; DRDY high after the first data-phase SCLK fall.
- MODE=1, ch0_i=24'hAAAAAA, ch1_i=24'h555555 -> successive RDATA return 0xAAAAAA, 0x555555, 0xAAAAAA with ch_o toggling.
- WREG aborted by CS rising after 10 bits -> cfg_o unchanged. nRST pulse -> cfg_o=0, DRDY=1, timer restarts from 0.
- Conversion completes mid-RDATA -> shifted word is the old sample; DRDY stays high until CS rises, then falls; next RDATA returns the new sample.
